hdlc_tx_sequencer: RTL and testbench
====================================

HDLC_TX_SEQUENCER -- requirements
Module: hdlc_tx_sequencer

Interface
REQ-001 Parameter MAX_FRAME, default 126: largest accepted Tx_FrameSize in bytes.
REQ-002 Clk  in  1  single clock; all logic on rising edge.
REQ-003 Rst  in  1  reset, synchronous, active-high.
REQ-004 Tx_Enable  in  1  start-frame pulse.
REQ-005 Tx_AbortFrame  in  1  abort-request pulse.
REQ-006 Tx_FrameSize  in  8  data byte count; sampled when the frame is accepted.
REQ-007 Tx_FCSen  in  1  append FCS; sampled when the frame is accepted.
REQ-008 Buf_RdEn  out  1  one-cycle read strobe to the Tx byte buffer.
REQ-009 Buf_Data  in  8  buffer byte, valid exactly one cycle after Buf_RdEn.
REQ-010 Tx  out  1  serial line, registered.
REQ-011 Tx_ValidFrame  out  1  high from the first start-flag bit through the last end-flag or abort bit.
REQ-012 Tx_Done  out  1  one-cycle pulse after a normal frame completes.
REQ-013 Tx_AbortedTrans  out  1  sticky abort status.

Function
REQ-014 States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT; one Tx bit per cycle; all bytes go LSB first.
REQ-015 IDLE: Tx=1, Tx_ValidFrame=0.
REQ-016 Accept in IDLE only: Tx_Enable=1 with 1<=Tx_FrameSize<=MAX_FRAME; size 0 or >MAX_FRAME is ignored with no output change.
REQ-017 Tx_Enable outside IDLE is ignored.
REQ-018 Accepted at edge N: first start-flag bit on Tx from N+1; flag pattern 0x7E = 0,1,1,1,1,1,1,0.
REQ-019 DATA emits Tx_FrameSize bytes in order; then FCS when Tx_FCSen=1, else END_FLAG directly.
REQ-020 Exactly one Buf_RdEn per data byte, issued while bit 6 of the preceding 8-bit unit (start flag or previous byte) is on Tx; stuff-stall cycles never re-issue it.
REQ-021 Buf_Data is captured in the cycle after Buf_RdEn.
REQ-022 Zero insertion (DATA and FCS only): after 5 consecutive emitted 1s, the next cycle emits 0 and the pending payload bit is held one cycle.
REQ-023 The ones counter clears on any emitted 0 and on entry to DATA.
REQ-024 A stuff bit required by the last payload bit is sent before END_FLAG.
REQ-025 Flags and abort pattern are never stuffed.
REQ-026 FCS: CRC-16/X-25 (reflected poly 0x8408, init 0xFFFF) over unstuffed data bits; transmitted complemented, low byte first, 16 bits.
REQ-027 END_FLAG: 8 bits 0x7E; Tx_Done=1 for the one cycle after the last flag bit, when Tx=1 and Tx_ValidFrame=0; then IDLE.
REQ-028 Abort: Tx_AbortFrame=1 at edge N while Tx_ValidFrame=1 -> ABORT from N+1, emitting 0,1,1,1,1,1,1,1, then IDLE.
REQ-029 Abort sets Tx_AbortedTrans=1 at N+2, held until the next accepted frame or reset; Buf_RdEn stays 0 and Tx_Done is not pulsed.
REQ-030 Abort has priority over every other transition, including the last END_FLAG bit; Tx_AbortFrame in IDLE or in ABORT is ignored.
REQ-031 Simultaneous Tx_Enable and Tx_AbortFrame in IDLE: the frame is accepted and the abort is ignored.

Reset
REQ-032 Rst=1 at an edge forces IDLE, Tx=1, Tx_ValidFrame=0, Buf_RdEn=0, Tx_Done=0, Tx_AbortedTrans=0, CRC=0xFFFF, ones counter=0.
REQ-033 Reset mid-frame takes effect next cycle: no Tx_Done, no abort pattern, no further Buf_RdEn.

Verification
REQ-034 Size=1, byte 0x00, FCSen=0 -> Tx = flag, 8 zeros, flag; Tx_ValidFrame high 24 cycles; one Buf_RdEn; one Tx_Done.
REQ-035 Size=1, byte 0xFF, FCSen=0 -> data field 1,1,1,1,1,0,1,1,1; Tx_ValidFrame high 25 cycles.
REQ-036 Size=9, bytes 0x31..0x39, FCSen=1 -> FCS bytes on the line (destuffed) 0x6E then 0x90; then flag; one Tx_Done.
REQ-037 Size=10, abort during byte 3 -> Tx 0 then seven 1s, then idle 1s; Tx_AbortedTrans high 2 edges after request; 3 Buf_RdEn total; no Tx_Done.
REQ-038 Size=0, size=127, and Tx_Enable while busy -> all ignored, no output change; reset mid-DATA -> Tx=1 and Tx_ValidFrame=0 next cycle.

Source files
------------

// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer: HDLC frame transmitter with flags, zero insertion, CRC-16/X-25 FCS and abort
module hdlc_tx_sequencer #(
  parameter int MAX_FRAME = 126
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_FrameSize,
  input  logic       Tx_FCSen,
  output logic       Buf_RdEn,
  input  logic [7:0] Buf_Data,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);
  typedef enum logic [2:0] {IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT} state_t;
  localparam logic [7:0] MAX_F = 8'(MAX_FRAME);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, nxt;
  logic        stuff_q, stuff_d;
  logic [2:0]  ones_q, ones_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  byte_q, byte_d, nbyte_q, nbyte_d, left_q, left_d;
  logic        rd_pend_q, rd_pend_d, fcsen_q, fcsen_d, aborted_q, aborted_d;
  logic        tx_q, tx_d, valid_q, valid_d, done_q, done_d, abort_go;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 16'h8408 : 16'h0000);
  endfunction
  assign Buf_RdEn = cnt_q == 4'd6 && !stuff_q && (state_q == START_FLAG || (state_q == DATA && left_q != 8'd0));
  assign Tx = tx_q;
  assign Tx_ValidFrame = valid_q;
  assign Tx_Done = done_q;
  assign Tx_AbortedTrans = aborted_q;
  // cnt_q indexes the bit now on Tx; each cycle picks the next line bit, a stuff bit holds the payload position
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stuff_d = 1'b0;
    byte_d = byte_q;
    left_d = left_q;
    fcsen_d = fcsen_q;
    aborted_d = aborted_q | (state_q == ABORT);
    tx_d = 1'b1;
    valid_d = 1'b0;
    done_d = 1'b0;
    nxt = cnt_q + 4'd1;
    rd_pend_d = Buf_RdEn;
    nbyte_d = rd_pend_q ? Buf_Data : nbyte_q;
    abort_go = Tx_AbortFrame && valid_q && state_q != ABORT;
    if (abort_go) begin
      state_d = ABORT;
      cnt_d = 4'd0;
      tx_d = 1'b0;
      valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (Tx_Enable && Tx_FrameSize != 8'd0 && Tx_FrameSize <= MAX_F) begin
          state_d = START_FLAG;
          cnt_d = 4'd0;
          tx_d = 1'b0;
          valid_d = 1'b1;
          left_d = Tx_FrameSize;
          fcsen_d = Tx_FCSen;
          aborted_d = 1'b0;
        end
        START_FLAG: begin
          valid_d = 1'b1;
          if (cnt_q != 4'd7) begin
            cnt_d = nxt;
            tx_d = cnt_q != 4'd6;
          end else begin
            state_d = DATA;
            cnt_d = 4'd0;
            byte_d = nbyte_d;
            left_d = left_q - 8'd1;
            tx_d = nbyte_d[0];
          end
        end
        DATA: begin
          valid_d = 1'b1;
          if (ones_q == 3'd5) begin
            tx_d = 1'b0;
            stuff_d = 1'b1;
          end else if (cnt_q != 4'd7) begin
            cnt_d = nxt;
            tx_d = byte_q[nxt[2:0]];
          end else if (left_q != 8'd0) begin
            cnt_d = 4'd0;
            byte_d = nbyte_d;
            left_d = left_q - 8'd1;
            tx_d = nbyte_d[0];
          end else if (fcsen_q) begin
            state_d = FCS;
            cnt_d = 4'd0;
            tx_d = ~crc_q[0];
          end else begin
            state_d = END_FLAG;
            cnt_d = 4'd0;
            tx_d = 1'b0;
          end
        end
        FCS: begin
          valid_d = 1'b1;
          if (ones_q == 3'd5) begin
            tx_d = 1'b0;
            stuff_d = 1'b1;
          end else if (cnt_q != 4'd15) begin
            cnt_d = nxt;
            tx_d = ~crc_q[nxt];
          end else begin
            state_d = END_FLAG;
            cnt_d = 4'd0;
            tx_d = 1'b0;
          end
        end
        END_FLAG: begin
          if (cnt_q != 4'd7) begin
            valid_d = 1'b1;
            cnt_d = nxt;
            tx_d = cnt_q != 4'd6;
          end else begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
        ABORT: if (cnt_q != 4'd7) begin
          valid_d = 1'b1;
          cnt_d = nxt;
        end else begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    ones_d = ((state_d == DATA || state_d == FCS) && !stuff_d && tx_d) ? ones_q + 3'd1 : 3'd0;
    crc_d = state_q == IDLE ? 16'hFFFF : (state_d == DATA && !stuff_d) ? crc_step(crc_q, tx_d) : crc_q;
  end
  // state and line registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      stuff_q <= 1'b0;
      ones_q <= 3'd0;
      crc_q <= 16'hFFFF;
      byte_q <= 8'd0;
      nbyte_q <= 8'd0;
      left_q <= 8'd0;
      rd_pend_q <= 1'b0;
      fcsen_q <= 1'b0;
      aborted_q <= 1'b0;
      tx_q <= 1'b1;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stuff_q <= stuff_d;
      ones_q <= ones_d;
      crc_q <= crc_d;
      byte_q <= byte_d;
      nbyte_q <= nbyte_d;
      left_q <= left_d;
      rd_pend_q <= rd_pend_d;
      fcsen_q <= fcsen_d;
      aborted_q <= aborted_d;
      tx_q <= tx_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// tb_hdlc_tx_sequencer: scoreboard bench for the HDLC transmitter
module tb_hdlc_tx_sequencer;
  logic Clk = 1'b0, Rst = 1'b1, Tx_Enable = 1'b0, Tx_AbortFrame = 1'b0, Tx_FCSen = 1'b0;
  logic [7:0] Tx_FrameSize = 8'd0;
  logic [7:0] Buf_Data;
  logic Buf_RdEn, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans;
  typedef struct {int len; int rd; bit done; bit empty;} frame_t;
  frame_t frames[$];
  frame_t mon_f;
  bit exp_bits[$];
  bit exp_aborted = 1'b0, started = 1'b0, prev_valid = 1'b0;
  logic [7:0] mem [0:1023];
  logic [7:0] pl [0:127];
  logic [9:0] rd_ptr = '0;
  int ones, checks = 0, fails = 0, vlen = 0, rd_cnt = 0;

  always #5 Clk = ~Clk;

  hdlc_tx_sequencer #(.MAX_FRAME(126)) dut (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
    .Tx_FrameSize(Tx_FrameSize), .Tx_FCSen(Tx_FCSen), .Buf_RdEn(Buf_RdEn),
    .Buf_Data(Buf_Data), .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame), .Tx_Done(Tx_Done),
    .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  // byte buffer: answers each read strobe one cycle later
  always @(posedge Clk) if (Buf_RdEn) begin
    Buf_Data <= mem[rd_ptr];
    rd_ptr <= rd_ptr + 10'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: pops expected line bits while a frame is on the wire, frame summary when it ends
  always @(posedge Clk) begin
    #1;
    if (started) begin
      if (Tx_ValidFrame) begin
        vlen = prev_valid ? vlen + 1 : 1;
        if (exp_bits.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL tx_extra_bit: got Tx=%0d with no expected bit (t=%0t)", Tx, $time);
        end else chk("tx_bit", int'(Tx), int'(exp_bits.pop_front()));
      end else begin
        chk("idle_tx", int'(Tx), 1);
        chk("idle_rd", int'(Buf_RdEn), 0);
        if (prev_valid) begin
          if (frames.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL frame_unexpected: got frame of %0d cycles, expected none", vlen);
          end else begin
            mon_f = frames.pop_front();
            chk("frame_len", vlen, mon_f.len);
            chk("rd_count", rd_cnt, mon_f.rd);
            chk("done", int'(Tx_Done), int'(mon_f.done));
            if (mon_f.empty) chk("bits_left", exp_bits.size(), 0);
          end
          rd_cnt = 0;
        end else chk("stray_done", int'(Tx_Done), 0);
      end
      if (Buf_RdEn) rd_cnt++;
      chk("aborted", int'(Tx_AbortedTrans), int'(exp_aborted));
      prev_valid = Tx_ValidFrame;
    end
  end

  task automatic push_unit(input logic [7:0] b, input bit stuff);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(b[i]);
      if (stuff) begin
        ones = b[i] ? ones + 1 : 0;
        if (ones == 5) begin
          exp_bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
  endtask

  task automatic kick(input int n, input bit fcs, input bit ab);
    Tx_FrameSize = 8'(n);
    Tx_FCSen = fcs;
    Tx_AbortFrame = ab;
    Tx_Enable = 1'b1;
    exp_aborted = 1'b0;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    Tx_AbortFrame = 1'b0;
  endtask

  task automatic send(input int n, input bit fcs, input logic [7:0] f0, input logic [7:0] f1,
                      input int len, input int rd, input bit ab);
    ones = 0;
    push_unit(8'h7E, 1'b0);
    for (int i = 0; i < n; i++) begin
      mem[rd_ptr + 10'(i)] = pl[i];
      push_unit(pl[i], 1'b1);
    end
    if (fcs) begin
      push_unit(f0, 1'b1);
      push_unit(f1, 1'b1);
    end
    push_unit(8'h7E, 1'b0);
    frames.push_back('{len, rd, 1'b1, 1'b1});
    kick(n, fcs, ab);
  endtask

  task automatic wait_done();
    int t = 0;
    while (frames.size() != 0 && t < 3000) begin
      @(negedge Clk);
      t++;
    end
    if (frames.size() != 0) begin
      $display("FAIL timeout: %0d frames still pending", frames.size());
      $fatal(1, "timeout");
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic zero_pl(input int n);
    for (int i = 0; i < n; i++) pl[i] = 8'h00;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    started = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    zero_pl(1);
    send(1, 1'b0, 8'h00, 8'h00, 24, 1, 1'b0);
    wait_done();
    pl[0] = 8'hFF;
    send(1, 1'b0, 8'h00, 8'h00, 25, 1, 1'b0);
    wait_done();
    pl[0] = 8'hF8;
    send(1, 1'b0, 8'h00, 8'h00, 25, 1, 1'b0);
    wait_done();
    pl[0] = 8'hFF;
    pl[1] = 8'hFF;
    send(2, 1'b0, 8'h00, 8'h00, 35, 2, 1'b0);
    wait_done();
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    send(9, 1'b1, 8'h6E, 8'h90, 104, 9, 1'b0);
    wait_done();
    ones = 0;
    for (int i = 0; i < 10; i++) mem[rd_ptr + 10'(i)] = 8'h00;
    push_unit(8'h7E, 1'b0);
    for (int i = 0; i < 20; i++) exp_bits.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_bits.push_back(1'b1);
    frames.push_back('{35, 3, 1'b0, 1'b1});
    kick(10, 1'b0, 1'b0);
    repeat (26) @(negedge Clk);
    Tx_AbortFrame = 1'b1;
    @(negedge Clk);
    Tx_AbortFrame = 1'b0;
    exp_aborted = 1'b1;
    wait_done();
    Tx_FrameSize = 8'd0;
    Tx_Enable = 1'b1;
    @(negedge Clk);
    Tx_FrameSize = 8'd127;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    Tx_AbortFrame = 1'b1;
    @(negedge Clk);
    Tx_AbortFrame = 1'b0;
    repeat (4) @(negedge Clk);
    zero_pl(1);
    send(1, 1'b0, 8'h00, 8'h00, 24, 1, 1'b1);
    repeat (3) @(negedge Clk);
    Tx_FrameSize = 8'd1;
    Tx_Enable = 1'b1;
    @(negedge Clk);
    Tx_Enable = 1'b0;
    wait_done();
    zero_pl(126);
    send(126, 1'b0, 8'h00, 8'h00, 1024, 126, 1'b0);
    wait_done();
    zero_pl(4);
    for (int i = 0; i < 4; i++) mem[rd_ptr + 10'(i)] = 8'h00;
    ones = 0;
    push_unit(8'h7E, 1'b0);
    for (int i = 0; i < 12; i++) exp_bits.push_back(1'b0);
    frames.push_back('{20, 2, 1'b0, 1'b1});
    kick(4, 1'b0, 1'b0);
    repeat (19) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    wait_done();
    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
